// File: rtl/proc_pkg.sv
// Shared types and defaults for the compute-and-stream processor block.
// Latency: none (types and constants only).
// Backpressure: none (types and constants only).
package proc_pkg;

    typedef enum logic [2:0] {
        IDLE,
        COMPUTE,
        DONE,
        STREAM,
        SENT
    } state_t;

    typedef logic [7:0] byte_t;

    localparam int DEF_DEPTH = 16;
    localparam int DEF_DIV   = 4;

endpackage

// File: rtl/proc_strobe_gen.sv
// Divide-by-DIV strobe generator that produces the per-byte read-enable tick.
// Latency: the tick is combinational, high while enabled and the count sits at DIV-1.
// Backpressure: a low en freezes the count, so a paused stream resumes mid-period.
module proc_strobe_gen
    import proc_pkg::*;
#(
    parameter int DIV = DEF_DIV
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] cnt;

    assign tick = en && (cnt == CW'(DIV - 1));

    // Count 0..DIV-1 while enabled; a clear restarts the period from zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= tick ? '0 : cnt + CW'(1);
        end
    end

endmodule

// File: rtl/proc_top.sv
// Fills a byte buffer with a running sum on a start edge, then streams it out on demand.
// Latency: EndFlag rises DEPTH+1 cycles after start is first sampled high; one byte per DIV cycles.
// Backpressure: startIO low pauses the stream; no byte is lost and the period resumes where it stopped.
module proc_top
    import proc_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH,
    parameter int DIV   = DEF_DIV
) (
    input  logic       clk_FPGA,
    input  logic       reset,
    input  logic       start,
    input  logic       startIO,
    output logic       EndFlag,
    output logic       clk_out,
    output logic [7:0] ReadDataOut
);

    localparam int             IW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [IW-1:0]  LAST = IW'(DEPTH - 1);

    state_t        state;
    byte_t         mem [DEPTH];
    logic [IW-1:0] idx;
    logic [IW-1:0] rd;
    byte_t         acc;
    byte_t         sum;
    logic          start_q, start_qq;
    logic          sio_q, sio_qq;
    logic          start_rise, sio_rise;
    logic          strobe_clr, strobe_en, tick;

    // Edges are taken from the registered copies so both inputs share one sampling point.
    assign start_rise = start_q & ~start_qq;
    assign sio_rise   = sio_q & ~sio_qq;
    assign sum        = acc + byte_t'(idx);
    assign strobe_en  = (state == STREAM) && sio_q;
    // The divider restarts whenever a fresh stream begins; a start edge pre-empts that.
    assign strobe_clr = !start_rise &&
                        (((state == DONE) && sio_q) || ((state == SENT) && sio_rise));

    proc_strobe_gen #(.DIV(DIV)) u_strobe (
        .clk   (clk_FPGA),
        .rst_n (reset),
        .clr   (strobe_clr),
        .en    (strobe_en),
        .tick  (tick)
    );

    // Sample the control inputs for edge detection.
    always_ff @(posedge clk_FPGA or negedge reset) begin
        if (!reset) begin
            start_q  <= 1'b0;
            start_qq <= 1'b0;
            sio_q    <= 1'b0;
            sio_qq   <= 1'b0;
        end else begin
            start_q  <= start;
            start_qq <= start_q;
            sio_q    <= startIO;
            sio_qq   <= sio_q;
        end
    end

    // Main sequencer: compute the running sum into the buffer, then stream it byte by byte.
    always_ff @(posedge clk_FPGA or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            EndFlag     <= 1'b0;
            clk_out     <= 1'b0;
            ReadDataOut <= '0;
            idx         <= '0;
            rd          <= '0;
            acc         <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            clk_out <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_rise) begin
                        state <= COMPUTE;
                        idx   <= '0;
                        acc   <= '0;
                    end
                end
                COMPUTE: begin
                    mem[idx] <= sum;
                    acc      <= sum;
                    if (idx == LAST) begin
                        state   <= DONE;
                        EndFlag <= 1'b1;
                    end else begin
                        idx <= idx + IW'(1);
                    end
                end
                DONE: begin
                    if (start_rise) begin
                        EndFlag <= 1'b0;
                        state   <= COMPUTE;
                        idx     <= '0;
                        acc     <= '0;
                    end else if (sio_q) begin
                        state <= STREAM;
                        rd    <= '0;
                    end
                end
                STREAM: begin
                    if (tick) begin
                        clk_out     <= 1'b1;
                        ReadDataOut <= mem[rd];
                        if (rd == LAST) begin
                            state <= SENT;
                        end else begin
                            rd <= rd + IW'(1);
                        end
                    end
                end
                SENT: begin
                    if (start_rise) begin
                        EndFlag <= 1'b0;
                        state   <= COMPUTE;
                        idx     <= '0;
                        acc     <= '0;
                    end else if (sio_rise) begin
                        state <= STREAM;
                        rd    <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_proc_top.sv
// Scoreboard bench for proc_top: randomized pauses and stray start pulses.
// Expected bytes come from the closed-form triangular-number sum k(k+1)/2 mod 256.
// A negedge monitor pops and compares every clk_out strobe independently of the stimulus.
module tb_proc_top;
    import proc_pkg::*;

    localparam int DEPTH = 16;
    localparam int DIV   = 4;

    logic       clk_FPGA = 1'b0;
    logic       reset;
    logic       start;
    logic       startIO;
    logic       EndFlag;
    logic       clk_out;
    logic [7:0] ReadDataOut;

    proc_top #(.DEPTH(DEPTH), .DIV(DIV)) dut (
        .clk_FPGA    (clk_FPGA),
        .reset       (reset),
        .start       (start),
        .startIO     (startIO),
        .EndFlag     (EndFlag),
        .clk_out     (clk_out),
        .ReadDataOut (ReadDataOut)
    );

    always #5 clk_FPGA = ~clk_FPGA;

    int cyc = 0;
    always @(posedge clk_FPGA) cyc <= cyc + 1;

    int         n_cmp = 0;
    int         n_err = 0;
    logic [7:0] exp_q[$];
    int         n_strobes = 0;
    int         last_strobe = 0;
    bit         skip_gap = 1'b1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: the k-th byte is the sum 0+1+..+k, wrapped to 8 bits.
    function automatic logic [7:0] ref_byte(input int k);
        return 8'((k * (k + 1)) / 2);
    endfunction

    task automatic push_stream();
        for (int k = 0; k < DEPTH; k++) exp_q.push_back(ref_byte(k));
    endtask

    task automatic start_pulse(output int e0);
        @(negedge clk_FPGA);
        start = 1'b1;
        e0    = cyc + 1;
        @(negedge clk_FPGA);
        start = 1'b0;
    endtask

    task automatic wait_endflag(input int e0);
        int b = 0;
        while (EndFlag !== 1'b1 && b < 60) begin
            @(negedge clk_FPGA);
            b++;
        end
        check("endflag_latency", cyc - e0, DEPTH + 1);
    endtask

    task automatic wait_strobes(input int target, input int budget);
        int b = 0;
        while (n_strobes < target && b < budget) begin
            @(negedge clk_FPGA);
            #1;
            b++;
        end
        check("strobe_count", n_strobes, target);
    endtask

    // Monitor: every strobe must carry the next expected byte at the DIV spacing.
    always @(negedge clk_FPGA) begin
        if (reset === 1'b1 && clk_out === 1'b1) begin
            check("strobe_while_paused", startIO, 1);
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_strobe: got byte %0d, expected no strobe (cycle %0d)",
                         ReadDataOut, cyc);
            end else begin
                check("stream_byte", ReadDataOut, exp_q.pop_front());
            end
            if (!skip_gap) check("strobe_gap", cyc - last_strobe, DIV);
            skip_gap    = 1'b0;
            last_strobe = cyc;
            n_strobes++;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int e0, e_ign, pk, pd, ik, ri;
        reset   = 1'b1;
        start   = 1'b0;
        startIO = 1'b1;
        #1 reset = 1'b0;

        // Reset values with startIO already high.
        repeat (2) @(negedge clk_FPGA);
        check("rst_endflag", EndFlag, 0);
        check("rst_clk_out", clk_out, 0);
        check("rst_data", ReadDataOut, 0);
        reset = 1'b1;
        repeat (2) @(negedge clk_FPGA);

        // First compute, then automatic stream with one random pause.
        push_stream();
        start_pulse(e0);
        wait_endflag(e0);
        pk = $urandom_range(14, 1);
        pd = $urandom_range(30, 5);
        wait_strobes(pk, 200);
        startIO  = 1'b0;
        skip_gap = 1'b1;
        repeat (pd) @(negedge clk_FPGA);
        #1;
        check("no_strobe_in_pause", n_strobes, pk);
        startIO = 1'b1;
        wait_strobes(DEPTH, 400);
        repeat (12) @(negedge clk_FPGA);
        check("sent_count", n_strobes, DEPTH);
        check("sent_endflag", EndFlag, 1);
        check("sent_hold_data", ReadDataOut, ref_byte(DEPTH - 1));

        // Restart from SENT via startIO 1->0->1, with a stray start pulse mid-stream.
        startIO = 1'b0;
        repeat (3) @(negedge clk_FPGA);
        #1;
        push_stream();
        skip_gap = 1'b1;
        startIO  = 1'b1;
        ik = $urandom_range(12, 1);
        wait_strobes(DEPTH + ik, 400);
        start_pulse(e_ign);
        wait_strobes(2 * DEPTH, 400);
        repeat (12) @(negedge clk_FPGA);
        check("restart_count", n_strobes, 2 * DEPTH);
        check("restart_endflag", EndFlag, 1);

        // Start in SENT: EndFlag drops, recompute ignores a stray start, stream follows.
        push_stream();
        skip_gap = 1'b1;
        start_pulse(e0);
        check("endflag_before_fall", EndFlag, 1);
        @(negedge clk_FPGA);
        check("endflag_fall", EndFlag, 0);
        ri = $urandom_range(8, 0);
        repeat (ri) @(negedge clk_FPGA);
        start_pulse(e_ign);
        wait_endflag(e0);
        wait_strobes(3 * DEPTH, 400);

        // Asynchronous reset mid-compute takes effect before any clock edge.
        start_pulse(e0);
        repeat (5) @(negedge clk_FPGA);
        #2 reset = 1'b0;
        #1;
        check("async_rst_endflag", EndFlag, 0);
        check("async_rst_clk_out", clk_out, 0);
        check("async_rst_data", ReadDataOut, 0);
        @(negedge clk_FPGA);
        reset = 1'b1;
        repeat (30) @(negedge clk_FPGA);
        check("idle_after_rst_endflag", EndFlag, 0);
        check("final_strobe_total", n_strobes, 3 * DEPTH);
        check("scoreboard_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
